// File: rtl/intc.sv
`default_nettype none
// ============================================================================
// Module   : intc
// Purpose  : Vectored interrupt controller: synchronizes IRQ lines, latches
//            pending requests, and runs the req/ack/eoi handshake to the CPU.
// Revision : 1.0 - initial release
// ============================================================================
module intc #(
    parameter int N_IRQ = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [31:0]      cfg_wdata,
    output logic [31:0]      cfg_rdata,
    output logic             int_req,
    output logic [4:0]       int_vec,
    input  logic             int_ack,
    input  logic             eoi
);

    localparam logic [1:0] c_addr_mask      = 2'd0;
    localparam logic [1:0] c_addr_edge      = 2'd1;
    localparam logic [1:0] c_addr_pending   = 2'd2;
    localparam logic [1:0] c_addr_inservice = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N_IRQ-1:0] sync1_q, sync1_d;
    logic [N_IRQ-1:0] sync2_q, sync2_d;
    logic [N_IRQ-1:0] sync3_q, sync3_d;
    logic [N_IRQ-1:0] mask_q, mask_d;
    logic [N_IRQ-1:0] edge_q, edge_d;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] inservice_q, inservice_d;
    logic             int_req_q, int_req_d;
    logic [4:0]       int_vec_q, int_vec_d;

    logic [N_IRQ-1:0] w_wdata;
    logic [N_IRQ-1:0] w_rise;
    logic [N_IRQ-1:0] w_w1c;
    logic [N_IRQ-1:0] w_ack_clr;
    logic [N_IRQ-1:0] w_active;
    logic [N_IRQ-1:0] w_vec_onehot;
    logic [4:0]       w_first;
    logic             w_ack_taken;
    logic             unused_wdata;

    assign w_wdata      = cfg_wdata[N_IRQ-1:0];
    assign unused_wdata = &{1'b0, cfg_wdata};
    assign w_rise       = sync2_q & ~sync3_q;
    assign w_active     = pending_q & mask_q;
    assign w_ack_taken  = (state_q == ST_REQ) && int_ack;
    assign w_w1c        = (cfg_we && (cfg_addr == c_addr_pending)) ? w_wdata : '0;
    assign w_ack_clr    = w_ack_taken ? w_vec_onehot : '0;

    // Lowest active index wins; scanning downward leaves the smallest one.
    always_comb begin
        w_first      = '0;
        w_vec_onehot = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_first = 5'(i);
            end
        end
        for (int i = 0; i < N_IRQ; i++) begin
            w_vec_onehot[i] = (int_vec_q == 5'(i));
        end
    end

    always_comb begin
        sync1_d = irq;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        mask_d  = (cfg_we && (cfg_addr == c_addr_mask)) ? w_wdata : mask_q;
        edge_d  = (cfg_we && (cfg_addr == c_addr_edge)) ? w_wdata : edge_q;
        // Edge sources: a new rising edge beats any clear in the same cycle.
        pending_d = (edge_q & ((pending_q & ~(w_w1c | w_ack_clr)) | w_rise))
                  | (~edge_q & sync2_q);
    end

    always_comb begin
        state_d     = state_q;
        int_req_d   = int_req_q;
        int_vec_d   = int_vec_q;
        inservice_d = inservice_q;
        case (state_q)
            ST_IDLE: begin
                if (|w_active) begin
                    state_d   = ST_REQ;
                    int_req_d = 1'b1;
                    int_vec_d = w_first;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    state_d     = ST_SERVICE;
                    int_req_d   = 1'b0;
                    inservice_d = w_vec_onehot;
                end
            end
            ST_SERVICE: begin
                if (eoi) begin
                    state_d     = ST_IDLE;
                    inservice_d = '0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                int_req_d   = 1'b0;
                inservice_d = '0;
            end
        endcase
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            c_addr_mask:      cfg_rdata = 32'(mask_q);
            c_addr_edge:      cfg_rdata = 32'(edge_q);
            c_addr_pending:   cfg_rdata = 32'(pending_q);
            c_addr_inservice: cfg_rdata = 32'(inservice_q);
            default:          cfg_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            sync1_q     <= '0;
            sync2_q     <= '0;
            sync3_q     <= '0;
            mask_q      <= '0;
            edge_q      <= '0;
            pending_q   <= '0;
            inservice_q <= '0;
            int_req_q   <= 1'b0;
            int_vec_q   <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sync3_q     <= sync3_d;
            mask_q      <= mask_d;
            edge_q      <= edge_d;
            pending_q   <= pending_d;
            inservice_q <= inservice_d;
            int_req_q   <= int_req_d;
            int_vec_q   <= int_vec_d;
        end
    end

    assign int_req = int_req_q;
    assign int_vec = int_vec_q;

endmodule
`default_nettype wire

// File: tb/tb_intc.sv
`default_nettype none
// ============================================================================
// Module   : tb_intc
// Purpose  : Self-checking bench for intc: register table, directed handshake
//            sequences, and randomized traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_intc;
    localparam int N = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  irq;
    logic          cfg_we;
    logic [1:0]    cfg_addr;
    logic [31:0]   cfg_wdata;
    logic [31:0]   cfg_rdata;
    logic          int_req;
    logic [4:0]    int_vec;
    logic          int_ack;
    logic          eoi;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    intc #(.N_IRQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq       (irq),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .int_req   (int_req),
        .int_vec   (int_vec),
        .int_ack   (int_ack),
        .eoi       (eoi)
    );

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] exp;
    } reg_vec_t;

    // Reference model state: behaviour expressed per source from the rules.
    logic [N-1:0] m_mask, m_edge, m_pend, m_insvc;
    logic [N-1:0] m_hist[$];
    int           m_phase;
    int           m_vec;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_reg(input logic [1:0] addr, input logic [31:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        cycle();
        cfg_we    = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] addr, input string name, input logic [31:0] exp);
        cfg_addr = addr;
        #1;
        chk(name, cfg_rdata, exp);
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        irq       = '0;
        cfg_we    = 1'b0;
        cfg_addr  = 2'd0;
        cfg_wdata = '0;
        int_ack   = 1'b0;
        eoi       = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
    endtask

    task automatic wait_req(input int max, input string name);
        int n = 0;
        while (!int_req && n < max) begin
            cycle();
            n++;
        end
        chk(name, 32'(int_req), 32'd1);
    endtask

    task automatic model_reset();
        m_mask  = '0;
        m_edge  = '0;
        m_pend  = '0;
        m_insvc = '0;
        m_phase = 0;
        m_vec   = 0;
        m_hist.delete();
        repeat (3) m_hist.push_back('0);
    endtask

    // Called once per rising edge with the inputs the DUT sampled there.
    task automatic model_step();
        logic [N-1:0] lvl, prev, np;
        lvl  = m_hist[1];
        prev = m_hist[2];
        np   = m_pend;
        for (int i = 0; i < N; i++) begin
            if (m_edge[i]) begin
                if (lvl[i] && !prev[i])
                    np[i] = 1'b1;
                else if ((cfg_we && cfg_addr == 2'd2 && cfg_wdata[i]) ||
                         (m_phase == 1 && int_ack && m_vec == i))
                    np[i] = 1'b0;
            end else begin
                np[i] = lvl[i];
            end
        end
        case (m_phase)
            0: if ((m_pend & m_mask) != 0) begin
                for (int i = N - 1; i >= 0; i--)
                    if (m_pend[i] && m_mask[i]) m_vec = i;
                m_phase = 1;
            end
            1: if (int_ack) begin
                m_phase        = 2;
                m_insvc        = '0;
                m_insvc[m_vec] = 1'b1;
            end
            2: if (eoi) begin
                m_phase = 0;
                m_insvc = '0;
            end
            default: m_phase = 0;
        endcase
        if (cfg_we && cfg_addr == 2'd0) m_mask = cfg_wdata[N-1:0];
        if (cfg_we && cfg_addr == 2'd1) m_edge = cfg_wdata[N-1:0];
        m_pend = np;
        m_hist.push_front(irq);
        void'(m_hist.pop_back());
    endtask

    function automatic logic [31:0] model_rdata(input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_mask);
            2'd1:    return 32'(m_edge);
            2'd2:    return 32'(m_pend);
            default: return 32'(m_insvc);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reg_vec_t tbl[11];
        tbl[0]  = '{1'b0, 2'd0, 32'h0,         2'd0, 32'h0};
        tbl[1]  = '{1'b0, 2'd0, 32'h0,         2'd1, 32'h0};
        tbl[2]  = '{1'b0, 2'd0, 32'h0,         2'd2, 32'h0};
        tbl[3]  = '{1'b0, 2'd0, 32'h0,         2'd3, 32'h0};
        tbl[4]  = '{1'b1, 2'd0, 32'h0000_00A5, 2'd0, 32'h0000_00A5};
        tbl[5]  = '{1'b1, 2'd1, 32'hFFFF_FF3C, 2'd1, 32'h0000_003C};
        tbl[6]  = '{1'b1, 2'd0, 32'h1234_5600, 2'd0, 32'h0};
        tbl[7]  = '{1'b1, 2'd3, 32'h0000_00FF, 2'd3, 32'h0};
        tbl[8]  = '{1'b1, 2'd2, 32'h0000_00FF, 2'd2, 32'h0};
        tbl[9]  = '{1'b0, 2'd0, 32'h0,         2'd1, 32'h0000_003C};
        tbl[10] = '{1'b1, 2'd1, 32'h0,         2'd1, 32'h0};

        // Register table
        do_reset();
        chk("reset_req", 32'(int_req), 32'd0);
        chk("reset_vec", 32'(int_vec), 32'd0);
        for (int i = 0; i < 11; i++) begin
            cfg_we    = tbl[i].we;
            cfg_addr  = tbl[i].addr;
            cfg_wdata = tbl[i].wdata;
            cycle();
            cfg_we = 1'b0;
            read_reg(tbl[i].raddr, $sformatf("table[%0d]", i), tbl[i].exp);
        end

        // Level source latency, ack and re-request after eoi
        do_reset();
        write_reg(2'd0, 32'h01);
        write_reg(2'd1, 32'h00);
        irq[0] = 1'b1;
        cycle(); chk("lvl_req_k",   32'(int_req), 32'd0);
        cycle(); chk("lvl_req_k1",  32'(int_req), 32'd0);
        cycle(); chk("lvl_req_k2",  32'(int_req), 32'd0);
        cycle(); chk("lvl_req_k3",  32'(int_req), 32'd1);
        chk("lvl_vec", 32'(int_vec), 32'd0);
        int_ack = 1'b1; cycle(); int_ack = 1'b0;
        chk("lvl_req_after_ack", 32'(int_req), 32'd0);
        read_reg(2'd3, "lvl_inservice", 32'h01);
        eoi = 1'b1; cycle(); eoi = 1'b0;
        chk("lvl_req_at_eoi", 32'(int_req), 32'd0);
        read_reg(2'd3, "lvl_inservice_cleared", 32'h00);
        cycle();
        chk("lvl_rereq", 32'(int_req), 32'd1);

        // Edge priority
        do_reset();
        write_reg(2'd1, 32'hFF);
        write_reg(2'd0, 32'hFF);
        irq = 8'h24;
        cycle(); cycle();
        irq = '0;
        wait_req(10, "edge_req1");
        chk("edge_vec1", 32'(int_vec), 32'd2);
        int_ack = 1'b1; cycle(); int_ack = 1'b0;
        read_reg(2'd2, "edge_pending", 32'h20);
        read_reg(2'd3, "edge_inservice", 32'h04);
        eoi = 1'b1; cycle(); eoi = 1'b0;
        wait_req(5, "edge_req2");
        chk("edge_vec2", 32'(int_vec), 32'd5);

        // Latched request survives masking and higher-priority arrival
        do_reset();
        write_reg(2'd0, 32'h08);
        irq = 8'h08;
        wait_req(10, "latch_req");
        chk("latch_vec", 32'(int_vec), 32'd3);
        write_reg(2'd0, 32'h01);
        irq = 8'h01;
        repeat (4) cycle();
        chk("latch_req_hold", 32'(int_req), 32'd1);
        chk("latch_vec_hold", 32'(int_vec), 32'd3);
        int_ack = 1'b1; cycle(); int_ack = 1'b0;
        chk("latch_req_ack", 32'(int_req), 32'd0);
        read_reg(2'd3, "latch_inservice", 32'h08);
        eoi = 1'b1; cycle(); eoi = 1'b0;
        wait_req(5, "latch_rereq");
        chk("latch_vec_new", 32'(int_vec), 32'd0);

        // W1C race: new rising edge on the same edge as the clearing write
        do_reset();
        write_reg(2'd1, 32'h02);
        irq[1] = 1'b1; cycle(); irq[1] = 1'b0;
        repeat (4) cycle();
        read_reg(2'd2, "w1c_pending_set", 32'h02);
        irq[1] = 1'b1;
        cycle(); cycle();
        cfg_we = 1'b1; cfg_addr = 2'd2; cfg_wdata = 32'h02;
        cycle();
        cfg_we = 1'b0;
        read_reg(2'd2, "w1c_race_set_wins", 32'h02);
        write_reg(2'd2, 32'h02);
        read_reg(2'd2, "w1c_plain_clear", 32'h00);
        irq[0] = 1'b1;
        repeat (3) cycle();
        write_reg(2'd2, 32'h01);
        read_reg(2'd2, "w1c_level_ignored", 32'h01);

        // Stray handshakes and read-only INSERVICE
        do_reset();
        int_ack = 1'b1; cycle(); int_ack = 1'b0;
        chk("stray_ack_req", 32'(int_req), 32'd0);
        read_reg(2'd3, "stray_ack_insvc", 32'h00);
        write_reg(2'd0, 32'h01);
        irq[0] = 1'b1;
        wait_req(10, "stray_req");
        eoi = 1'b1; cycle(); eoi = 1'b0;
        chk("stray_eoi_req", 32'(int_req), 32'd1);
        read_reg(2'd3, "stray_eoi_insvc", 32'h00);
        int_ack = 1'b1; eoi = 1'b1; cycle(); int_ack = 1'b0; eoi = 1'b0;
        chk("ackeoi_req", 32'(int_req), 32'd0);
        read_reg(2'd3, "ackeoi_insvc", 32'h01);
        write_reg(2'd3, 32'hFF);
        read_reg(2'd3, "insvc_readonly", 32'h01);
        repeat (3) cycle();
        chk("no_nesting", 32'(int_req), 32'd0);

        // Reset mid-request
        eoi = 1'b1; cycle(); eoi = 1'b0;
        wait_req(5, "rst_prep_req");
        rst = 1'b0;
        #1;
        chk("rst_req", 32'(int_req), 32'd0);
        chk("rst_vec", 32'(int_vec), 32'd0);
        for (int a = 0; a < 4; a++) read_reg(2'(a), $sformatf("rst_rdata[%0d]", a), 32'h0);
        irq = '0;
        cycle();
        rst = 1'b1;
        cycle(); cycle();
        chk("rst_idle", 32'(int_req), 32'd0);
        write_reg(2'd0, 32'h01);
        irq[0] = 1'b1;
        wait_req(6, "rst_restart");

        // Randomized traffic against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 7) == 0) irq[b] = ~irq[b];
            cfg_we    = ($urandom_range(0, 7) == 0);
            cfg_addr  = 2'($urandom_range(0, 3));
            cfg_wdata = $urandom;
            int_ack   = ($urandom_range(0, 2) == 0);
            eoi       = ($urandom_range(0, 3) == 0);
            #1;
            chk("rnd_req",   32'(int_req), 32'(m_phase == 1));
            chk("rnd_vec",   32'(int_vec), 32'(m_vec));
            chk("rnd_rdata", cfg_rdata, model_rdata(cfg_addr));
            @(posedge clk);
            model_step();
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
